// File: rtl/sha256_mem_responder.sv
// Memory-side responder for the SHA-256 engine: word RAM, host message loader,
// engine start/run sequencing and digest streaming back to the host.
module sha256_mem_responder #(
    parameter int DEPTH        = 256,
    parameter int MSG_WORDS    = 20,
    parameter int DIGEST_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [15:0] load_base,
    input  logic [15:0] out_base,
    output logic        start,
    input  logic        done,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        dig_valid,
    input  logic        dig_ready,
    output logic [31:0] dig_data,
    output logic        dig_last,
    output logic        busy,
    output logic [15:0] run_cycles,
    output logic [2:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MSG_WORDS + 1);
    localparam int KW = $clog2(DIGEST_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t        state;
    logic [31:0]   ram [DEPTH];
    logic [15:0]   load_base_q;
    logic [15:0]   out_base_q;
    logic [CW-1:0] cnt;
    logic [KW-1:0] dig_k;
    logic          load_fire;
    logic [15:0]   load_addr;
    logic [15:0]   drain_addr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;

    // Both streams use valid/ready: a beat transfers on a rising edge where
    // valid and ready are both high; the sender holds payload stable until then.
    assign load_ready = (state == S_IDLE) || (state == S_LOAD);
    assign load_fire  = load_valid && load_ready;
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;

    // The first beat uses the live base input since the latched copy is not yet valid.
    assign load_addr  = (state == S_IDLE) ? load_base : (load_base_q + 16'(cnt));
    assign drain_addr = out_base_q + 16'(dig_k);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (reset_n) begin
            if (load_fire) begin
                ram_we    = 1'b1;
                ram_waddr = load_addr[AW-1:0];
                ram_wdata = load_data;
            end else if ((state == S_RUN) && mem_we) begin
                ram_we    = 1'b1;
                ram_waddr = mem_addr[AW-1:0];
                ram_wdata = mem_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Read-before-write: a same-cycle write to this address is seen next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_read_data <= '0;
        end else begin
            mem_read_data <= ram[mem_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            start       <= 1'b0;
            dig_valid   <= 1'b0;
            dig_last    <= 1'b0;
            dig_data    <= '0;
            run_cycles  <= '0;
            cnt         <= '0;
            dig_k       <= '0;
            load_base_q <= '0;
            out_base_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_fire) begin
                        load_base_q <= load_base;
                        out_base_q  <= out_base;
                        cnt         <= CW'(1);
                        if (MSG_WORDS == 1) begin
                            state      <= S_START;
                            start      <= 1'b1;
                            run_cycles <= '0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(MSG_WORDS - 1)) begin
                            state      <= S_START;
                            start      <= 1'b1;
                            run_cycles <= '0;
                        end
                    end
                end
                S_START: begin
                    // Engine reports done high while idle; it has taken start once done falls.
                    if (!done) begin
                        start <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (done) begin
                        state <= S_DRAIN;
                        dig_k <= '0;
                    end
                end
                S_DRAIN: begin
                    if (!dig_valid) begin
                        dig_data  <= ram[drain_addr[AW-1:0]];
                        dig_last  <= (dig_k == KW'(DIGEST_WORDS - 1));
                        dig_valid <= 1'b1;
                    end else if (dig_ready) begin
                        dig_valid <= 1'b0;
                        dig_last  <= 1'b0;
                        if (dig_last) begin
                            state <= S_IDLE;
                        end else begin
                            dig_k <= dig_k + KW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
